// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
//   N_REQ   : number of requesters
//   SEL_W   : width of the owner index / MUX4 select
//   CNT_W   : width of the hold counter (covers HOLD_MAX up to 255)
//   state_t : arbiter FSM states
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Arbiter bus bundle.
//   req     : request vector from the requesters
//   done    : completion strobe from the shared resource
//   grant   : one-hot grant
//   sel     : binary owner index (MUX4 select)
//   valid   : a grant is active
//   timeout : pulse when a grant was force-released by the hold limit
// master = requester/resource side, slave = arbiter side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, sel, valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, sel, valid, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request searching upward from i_ptr,
// wrapping 3 -> 0.
//   i_req    : request vector
//   i_ptr    : highest-priority index for this round
//   o_winner : index of the selected requester (i_ptr when none)
//   o_any    : at least one request is asserted
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  logic [SEL_W-1:0] w_idx;

  // Index arithmetic wraps naturally in SEL_W bits.
  always_comb begin
    o_winner = i_ptr;
    o_any    = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = i_ptr + SEL_W'(k);
      if (!o_any && i_req[w_idx]) begin
        o_winner = w_idx;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with hold limit and one-cycle turnaround.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : rr_arbiter4_if.slave (req/done in, grant/sel/valid/timeout out)
//   HOLD_MAX : maximum cycles a grant is held before forced release (1..255)
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           r_state,   w_state_nxt;
  logic [SEL_W-1:0] r_ptr,     w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [N_REQ-1:0] r_grant,   w_grant_nxt;
  logic [SEL_W-1:0] r_sel,     w_sel_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_timeout, w_timeout_nxt;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_drop;
  logic             w_hold_hit;

  rr_pick u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // r_sel doubles as the owner index while BUSY.
  assign w_drop     = ~bus.req[r_sel];
  assign w_hold_hit = (r_cnt == HOLD_LAST);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        // done is ignored here; only requests matter.
        if (w_any) begin
          w_state_nxt = BUSY;
          w_grant_nxt = onehot(w_winner);
          w_sel_nxt   = w_winner;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_winner + SEL_W'(1);
          w_cnt_nxt   = '0;
        end else begin
          w_grant_nxt = '0;
          w_valid_nxt = 1'b0;
        end
      end
      BUSY: begin
        // Release always returns to IDLE, which gives the turnaround gap.
        if (bus.done || w_drop || w_hold_hit) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = '0;
          w_valid_nxt   = 1'b0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = w_hold_hit && !bus.done && !w_drop;
        end else begin
          // Cannot pass HOLD_LAST: reaching it forces release above.
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.grant   = r_grant;
  assign bus.sel     = r_sel;
  assign bus.valid   = r_valid;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 (HOLD_MAX = 4): directed vector table,
// hand-written reset sequences, then random traffic against a reference model.
module tb_rr_arbiter4;

  localparam int HOLD = 4;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       timeout;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: owner index (-1 = none), next-round start index,
  // cycles the current owner has held the grant, last owner index.
  int m_owner, m_ptr, m_held, m_sel, m_to;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic dn);
    bit by_done, by_drop, by_hold;
    if (r) begin
      model_reset();
      return;
    end
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (m_owner < 0 && rq[idx]) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_sel  = m_owner;
        m_ptr  = (m_owner + 1) % 4;
        m_held = 1;
      end
    end else begin
      by_done = dn;
      by_drop = !rq[m_owner];
      by_hold = (m_held == HOLD);
      if (by_done || by_drop || by_hold) begin
        m_to    = (by_hold && !by_done && !by_drop) ? 1 : 0;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input logic t);
    chk({tag, ".grant"},   bus.grant,          g);
    chk({tag, ".sel"},     4'(bus.sel),        4'(s));
    chk({tag, ".valid"},   4'(bus.valid),      4'(v));
    chk({tag, ".timeout"}, 4'(bus.timeout),    4'(t));
  endtask

  // Drive inputs, take one edge, sample 1 time unit later.
  task automatic cycle(input logic [3:0] rq, input logic dn);
    bus.req  = rq;
    bus.done = dn;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  task automatic add(input logic [3:0] rq, input logic dn, input logic [3:0] g,
                     input logic [1:0] s, input logic v, input logic t);
    vec_t e;
    e.req = rq; e.done = dn; e.grant = g; e.sel = s; e.valid = v; e.timeout = t;
    tbl.push_back(e);
  endtask

  initial begin
    logic [3:0] rq;
    logic       dn;
    logic       rr;
    logic [3:0] eg;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.done = 1'b0;

    // Full rotation with done one cycle after each grant.
    add(4'hF,0,4'b0001,2'd0,1,0); add(4'hF,1,4'b0000,2'd0,0,0);
    add(4'hF,0,4'b0010,2'd1,1,0); add(4'hF,1,4'b0000,2'd1,0,0);
    add(4'hF,0,4'b0100,2'd2,1,0); add(4'hF,1,4'b0000,2'd2,0,0);
    add(4'hF,0,4'b1000,2'd3,1,0); add(4'hF,1,4'b0000,2'd3,0,0);
    add(4'hF,0,4'b0001,2'd0,1,0); add(4'hF,1,4'b0000,2'd0,0,0);
    // Hold limit: four grant cycles, then forced release with timeout.
    add(4'h4,0,4'b0100,2'd2,1,0); add(4'h4,0,4'b0100,2'd2,1,0);
    add(4'h4,0,4'b0100,2'd2,1,0); add(4'h4,0,4'b0100,2'd2,1,0);
    add(4'h4,0,4'b0000,2'd2,0,1); add(4'h0,0,4'b0000,2'd2,0,0);
    // done on the last allowed cycle wins over timeout.
    add(4'h4,0,4'b0100,2'd2,1,0); add(4'h4,0,4'b0100,2'd2,1,0);
    add(4'h4,0,4'b0100,2'd2,1,0); add(4'h4,0,4'b0100,2'd2,1,0);
    add(4'h4,1,4'b0000,2'd2,0,0); add(4'h0,0,4'b0000,2'd2,0,0);
    // Request drop releases; non-owner changes ignored while busy.
    add(4'h1,0,4'b0001,2'd0,1,0); add(4'h0,0,4'b0000,2'd0,0,0);
    add(4'hA,0,4'b0010,2'd1,1,0); add(4'hE,0,4'b0010,2'd1,1,0);
    add(4'h8,0,4'b0000,2'd1,0,0); add(4'h8,0,4'b1000,2'd3,1,0);
    add(4'h0,0,4'b0000,2'd3,0,0);
    // done while idle is ignored.
    add(4'h0,1,4'b0000,2'd3,0,0); add(4'h0,0,4'b0000,2'd3,0,0);
    // Wrap-around: ptr=2 after owner 1, req 0011 picks 0.
    add(4'h2,0,4'b0010,2'd1,1,0); add(4'h0,0,4'b0000,2'd1,0,0);
    add(4'h3,0,4'b0001,2'd0,1,0); add(4'h3,1,4'b0000,2'd0,0,0);

    @(posedge clk);
    #1;
    chk_outputs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cycle(tbl[i].req, tbl[i].done);
      chk_outputs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel, tbl[i].valid, tbl[i].timeout);
    end

    // Asynchronous reset while owner 1 holds the grant (ptr is 2 by then).
    cycle(4'b0010, 1'b0);
    chk_outputs("pre_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk_outputs("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req = 4'b1001;
    @(posedge clk);
    #1;
    chk_outputs("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(4'b1001, 1'b0);
    chk_outputs("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Random traffic against the reference model.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    rq = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      dn = ($urandom_range(0, 3) == 0);
      rst = rr;
      cycle(rq, dn);
      model_edge(rr, rq, dn);
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      chk_outputs($sformatf("rnd%0d", n), eg, 2'(m_sel), (m_owner >= 0), m_to[0]);
      chk("rnd.onehot", 4'($countones(bus.grant) <= 1), 4'd1);
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
